// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: widths, operation codes,
// FSM states and small decode helpers.
package calc_pkg;

    localparam int RESULT_W  = 32;
    localparam int OPERAND_W = 8;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_MUL = 3'b010;
    localparam logic [2:0] FUNC_DIV = 3'b011;
    localparam logic [2:0] FUNC_MOD = 3'b100;
    localparam logic [2:0] FUNC_SQR = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Codes 110 and 111 are reserved and are ignored by the sequencer.
    function automatic logic func_valid(input logic [2:0] f);
        return f <= FUNC_SQR;
    endfunction

    function automatic logic func_is_div(input logic [2:0] f);
        return (f == FUNC_DIV) || (f == FUNC_MOD);
    endfunction

endpackage

// File: rtl/calc_iter_div.sv
// Iterative restoring divider: 32-bit dividend, 8-bit divisor, one quotient
// bit per cycle. The last iteration is presented combinationally together
// with done, so the caller captures the final result on that same edge.
module calc_iter_div
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RESULT_W-1:0]  dividend,
    input  logic [OPERAND_W-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [RESULT_W-1:0]  quotient,
    output logic [OPERAND_W-1:0] remainder
);

    logic [RESULT_W-1:0]  q_r;
    logic [OPERAND_W-1:0] r_r;
    logic [OPERAND_W-1:0] d_r;
    logic [5:0]           cnt_r;
    logic                 busy_r;

    logic [OPERAND_W:0]   shifted;
    logic [OPERAND_W:0]   diff;
    logic                 ge;
    logic [RESULT_W-1:0]  q_nxt;
    logic [OPERAND_W-1:0] r_nxt;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The remainder stays below the
    // divisor, so 8 bits plus the shifted-in bit are enough.
    always_comb begin
        shifted = {r_r, q_r[RESULT_W-1]};
        diff    = shifted - {1'b0, d_r};
        ge      = shifted >= {1'b0, d_r};
        r_nxt   = ge ? diff[OPERAND_W-1:0] : shifted[OPERAND_W-1:0];
        q_nxt   = {q_r[RESULT_W-2:0], ge};
    end

    assign busy      = busy_r;
    assign done      = busy_r && (cnt_r == 6'd1);
    assign quotient  = q_nxt;
    assign remainder = r_nxt;

    // Iteration registers with a down-counter of remaining steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            r_r    <= '0;
            d_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (abort) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            q_r    <= dividend;
            r_r    <= '0;
            d_r    <= divisor;
            cnt_r  <= 6'd32;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            q_r   <= q_nxt;
            r_r   <= r_nxt;
            cnt_r <= cnt_r - 6'd1;
            if (cnt_r == 6'd1) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Button-operated accumulating calculator. A debounced key press launches one
// operation on num1/num2 (or on the held result when chaining); divide and
// modulo run on the iterative divider, everything else completes in one step.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no prior result, operand A comes from num1
// ST_READY | result held, operand A comes from cal_result
// ST_EXEC  | single-step op (or divide-by-zero) being committed
// ST_DIV   | divider iterating
// ST_DONE  | one-cycle completion pulse
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 button,
    input  logic                 clear,
    input  logic [2:0]           func,
    input  logic [OPERAND_W-1:0] num1,
    input  logic [OPERAND_W-1:0] num2,
    output logic [RESULT_W-1:0]  cal_result,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int            DB_W       = $clog2(DB_CYCLES + 2) + 1;
    localparam logic [DB_W-1:0] DB_RELOAD  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] ARM_RELOAD = DB_W'(DB_CYCLES + 1);
    localparam int            PAD_W      = RESULT_W - OPERAND_W;

    logic                 sync1, sync2;
    logic                 db_level, db_prev;
    logic [DB_W-1:0]      db_cnt;
    logic                 armed;
    logic [DB_W-1:0]      arm_cnt;
    logic                 go;

    state_t               state, state_nxt;
    logic                 accept;
    logic                 div_start;
    logic [2:0]           func_q;
    logic [RESULT_W-1:0]  a_q, b_q;
    logic [RESULT_W-1:0]  op_a, op_b, sq_op;

    logic                 div_busy, div_done;
    logic [RESULT_W-1:0]  div_quot;
    logic [OPERAND_W-1:0] div_rem;

    // Two-flop synchroniser for the raw key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Debouncer: the level flips after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= DB_RELOAD;
        end else begin
            db_prev <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= DB_RELOAD;
            end else if (db_cnt == '0) begin
                db_level <= sync2;
                db_cnt   <= DB_RELOAD;
            end else begin
                db_cnt <= db_cnt - DB_W'(1);
            end
        end
    end

    // Key is armed only after a clean low stretch, so a key held through reset
    // must be released before it can launch anything. The stretch is longer
    // than the synchroniser flush so the post-reset zeros cannot arm it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_cnt <= ARM_RELOAD;
        end else if (!armed) begin
            if (sync2 || db_level) begin
                arm_cnt <= ARM_RELOAD;
            end else if (arm_cnt == '0) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt - DB_W'(1);
            end
        end
    end

    assign go     = db_level & ~db_prev & armed;
    assign accept = go && !clear && func_valid(func)
                    && ((state == ST_IDLE) || (state == ST_READY));

    assign op_a  = (state == ST_READY) ? cal_result : {{PAD_W{1'b0}}, num1};
    assign op_b  = {{PAD_W{1'b0}}, num2};
    assign sq_op = (state == ST_READY) ? cal_result : op_b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides everything, including a running divide.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        state_nxt = (func_is_div(func) && (num2 != '0)) ? ST_DIV : ST_EXEC;
                    end
                end
                ST_EXEC:  state_nxt = ST_DONE;
                ST_DIV:   if (div_done || !div_busy) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_READY;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state and the launch condition.
    always_comb begin
        busy      = (state == ST_EXEC) || (state == ST_DIV);
        done      = (state == ST_DONE);
        div_start = accept && func_is_div(func) && (num2 != '0);
    end

    // Operand capture at launch, then result and sticky error update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_result <= '0;
            err        <= 1'b0;
            func_q     <= FUNC_ADD;
            a_q        <= '0;
            b_q        <= '0;
        end else if (clear) begin
            cal_result <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                func_q <= func;
                a_q    <= (func == FUNC_SQR) ? sq_op : op_a;
                b_q    <= (func == FUNC_SQR) ? sq_op : op_b;
            end
            if (state == ST_EXEC) begin
                case (func_q)
                    FUNC_ADD:           cal_result <= a_q + b_q;
                    FUNC_SUB:           cal_result <= a_q - b_q;
                    FUNC_MUL, FUNC_SQR: cal_result <= a_q * b_q;
                    default:            err        <= 1'b1;
                endcase
            end
            if ((state == ST_DIV) && div_done) begin
                cal_result <= (func_q == FUNC_DIV) ? div_quot : {{PAD_W{1'b0}}, div_rem};
            end
        end
    end

    calc_iter_div u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (clear),
        .dividend  (op_a),
        .divisor   (num2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

endmodule
